rr_max_scheduler: RTL and testbench

Sequencing arbiter that shares one 8-bit magnitude comparator among N requesters, each presenting an attribute value. On start it scans the requesters serially in round-robin order from the last winner. It keeps the running maximum attribute, then issues one grant and holds it until acknowledged. It sits ahead of the round-robin register chain and selects the next entry to load into the attribute buffer.

---
 rtl/rr_sched_pkg.sv | 15 +
 rtl/attr_cmp.sv | 37 +++
 rtl/rr_max_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_rr_max_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// rtl/rr_sched_pkg.sv - shared state type and constants for the round-robin max scheduler
package rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } sched_state_t;

    localparam int N_DEF = 4;
    localparam int W_DEF = 8;

    localparam logic [1:0] STARVE_LIMIT = 2'd3;

endpackage

// File: rtl/attr_cmp.sv
// rtl/attr_cmp.sv - combinational unsigned magnitude comparator built from two halves
module attr_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_agb,
    output logic         o_aeqb
);

    localparam int LW = W / 2;
    localparam int HW = W - LW;

    logic [HW-1:0] w_a_hi;
    logic [HW-1:0] w_b_hi;
    logic [LW-1:0] w_a_lo;
    logic [LW-1:0] w_b_lo;
    logic          w_hi_gt;
    logic          w_hi_eq;
    logic          w_lo_gt;
    logic          w_lo_eq;

    assign w_a_hi = i_a[W-1:LW];
    assign w_b_hi = i_b[W-1:LW];
    assign w_a_lo = i_a[LW-1:0];
    assign w_b_lo = i_b[LW-1:0];

    assign w_hi_gt = (w_a_hi > w_b_hi);
    assign w_hi_eq = (w_a_hi == w_b_hi);
    assign w_lo_gt = (w_a_lo > w_b_lo);
    assign w_lo_eq = (w_a_lo == w_b_lo);

    // The low half only decides when the high halves tie.
    assign o_agb  = w_hi_gt | (w_hi_eq & w_lo_gt);
    assign o_aeqb = w_hi_eq & w_lo_eq;

endmodule

// File: rtl/rr_max_scheduler.sv
// rtl/rr_max_scheduler.sv - serial round-robin max-attribute arbiter sharing one comparator
// Optional starvation guard (2-bit loss counters) enabled by defining STARVE_GUARD_EN.
module rr_max_scheduler
    import rr_sched_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int W   = W_DEF,
    parameter int IDW = 2
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             start,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   attr,
    output logic             busy,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic [W-1:0]     grant_attr,
    input  logic             ack
);

    localparam logic [IDW:0] N_W = (IDW+1)'(N);

    sched_state_t   r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_k;
    logic [IDW-1:0] r_best_id;
    logic [W-1:0]   r_best_attr;
    logic           r_found;
    logic           r_busy;
    logic           r_grant_valid;
    logic [IDW-1:0] r_grant_id;
    logic [W-1:0]   r_grant_attr;

    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic           w_cur_req;
    logic [W-1:0]   w_cur_attr;
    logic           w_agb;
    logic           w_aeqb;
    logic           w_take;
    logic           w_upd;
    logic           w_last;
    logic           w_nxt_found;
    logic [IDW-1:0] w_nxt_best_id;
    logic [W-1:0]   w_nxt_best_attr;
    logic           w_enter_grant;

`ifdef STARVE_GUARD_EN
    logic [1:0]     r_loss [N];
    logic           r_best_sat;
    logic [1:0]     w_cur_loss;
    logic           w_cur_sat;
`endif

    // Scan index walks forward from the slot after the last winner.
    assign w_sum  = {1'b0, r_ptr} + {1'b0, r_k} + (IDW+1)'(1);
    assign w_idx  = (w_sum >= N_W) ? IDW'(w_sum - N_W) : IDW'(w_sum);
    assign w_last = (r_k == IDW'(N-1));

    always_comb begin
        w_cur_req  = 1'b0;
        w_cur_attr = '0;
        for (int j = 0; j < N; j++) begin
            if (w_idx == IDW'(j)) begin
                w_cur_req  = req[j];
                w_cur_attr = attr[j*W +: W];
            end
        end
    end

    attr_cmp #(.W(W)) u_cmp (
        .i_a    (w_cur_attr),
        .i_b    (r_best_attr),
        .o_agb  (w_agb),
        .o_aeqb (w_aeqb)
    );

`ifdef STARVE_GUARD_EN
    always_comb begin
        w_cur_loss = '0;
        for (int j = 0; j < N; j++) begin
            if (w_idx == IDW'(j)) w_cur_loss = r_loss[j];
        end
    end
`endif

    // Ties never replace the incumbent, so the earlier scan position keeps the grant.
    always_comb begin
        w_take = 1'b0;
`ifdef STARVE_GUARD_EN
        w_cur_sat = (w_cur_loss == STARVE_LIMIT);
        if (!r_found)                    w_take = 1'b1;
        else if (w_cur_sat != r_best_sat) w_take = w_cur_sat;
        else if (!w_cur_sat)             w_take = w_agb & ~w_aeqb;
`else
        w_take = !r_found || (w_agb && !w_aeqb);
`endif
    end

    assign w_upd           = (r_state == SCAN) && w_cur_req && w_take;
    assign w_nxt_found     = r_found | w_upd;
    assign w_nxt_best_id   = w_upd ? w_idx : r_best_id;
    assign w_nxt_best_attr = w_upd ? w_cur_attr : r_best_attr;
    assign w_enter_grant   = (r_state == SCAN) && w_last && w_nxt_found;

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            r_state       <= IDLE;
            r_ptr         <= IDW'(N-1);
            r_k           <= '0;
            r_best_id     <= '0;
            r_best_attr   <= '0;
            r_found       <= 1'b0;
            r_busy        <= 1'b0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_grant_attr  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (|req)) begin
                        r_state <= SCAN;
                        r_busy  <= 1'b1;
                        r_k     <= '0;
                        r_found <= 1'b0;
                    end
                end
                SCAN: begin
                    r_found     <= w_nxt_found;
                    r_best_id   <= w_nxt_best_id;
                    r_best_attr <= w_nxt_best_attr;
                    r_k         <= r_k + 1'b1;
                    if (w_last) begin
                        if (w_nxt_found) begin
                            r_state       <= GRANT;
                            r_grant_valid <= 1'b1;
                            r_grant_id    <= w_nxt_best_id;
                            r_grant_attr  <= w_nxt_best_attr;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    if (ack) begin
                        r_ptr         <= r_best_id;
                        r_grant_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef STARVE_GUARD_EN
    // Losers that were still requesting age by one; everyone else starts over.
    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            for (int j = 0; j < N; j++) r_loss[j] <= 2'd0;
            r_best_sat <= 1'b0;
        end else begin
            if (w_upd) r_best_sat <= w_cur_sat;
            if (w_enter_grant) begin
                for (int j = 0; j < N; j++) begin
                    if (req[j] && (IDW'(j) != w_nxt_best_id))
                        r_loss[j] <= (r_loss[j] == STARVE_LIMIT) ? r_loss[j] : r_loss[j] + 2'd1;
                    else
                        r_loss[j] <= 2'd0;
                end
            end
        end
    end
`endif

    assign busy        = r_busy;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign grant_attr  = r_grant_attr;

endmodule

// File: tb/tb_rr_max_scheduler.sv
// tb/tb_rr_max_scheduler.sv - directed self-checking bench for rr_max_scheduler
module tb_rr_max_scheduler;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           CK    = 1'b0;
    logic           CLR   = 1'b0;
    logic           start = 1'b0;
    logic           ack   = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] attr  = '0;
    logic           busy;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic [W-1:0]   grant_attr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 CK = ~CK;

    rr_max_scheduler #(.N(N), .W(W), .IDW(IDW)) dut (
        .CK          (CK),
        .CLR         (CLR),
        .start       (start),
        .req         (req),
        .attr        (attr),
        .busy        (busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_attr  (grant_attr),
        .ack         (ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        #2;
        CLR = 1'b0;
        tick();
        tick();
        CLR = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk($sformatf("%s.busy", tag), busy, 0);
        chk($sformatf("%s.gv", tag), grant_valid, 0);
        chk($sformatf("%s.gid", tag), grant_id, 0);
        chk($sformatf("%s.gattr", tag), grant_attr, 0);
    endtask

    task automatic run_round(input logic [N-1:0] rq, input logic [N*W-1:0] at,
                             input logic [IDW-1:0] eid, input logic [W-1:0] eattr,
                             input string tag);
        req   = rq;
        attr  = at;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("%s.busy_on", tag), busy, 1);
        repeat (N-1) tick();
        chk($sformatf("%s.early_gv", tag), grant_valid, 0);
        tick();
        chk($sformatf("%s.gv", tag), grant_valid, 1);
        chk($sformatf("%s.gid", tag), grant_id, eid);
        chk($sformatf("%s.gattr", tag), grant_attr, eattr);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk($sformatf("%s.busy_off", tag), busy, 0);
        chk($sformatf("%s.gv_off", tag), grant_valid, 0);
    endtask

    initial begin
        logic [N*W-1:0] eq_attr;
        logic [N*W-1:0] starve_attr;
        logic [IDW-1:0] sid [4];
        logic [W-1:0]   sattr [4];
        eq_attr     = {8'h40, 8'h40, 8'h40, 8'h40};
        starve_attr = {8'h00, 8'h00, 8'h01, 8'hFF};

        tick();
        tick();
        chk_idle_outputs("reset");
        CLR = 1'b1;

        run_round(4'b1111, {8'h10, 8'h80, 8'h22, 8'h05}, 2'd2, 8'h80, "max");

        do_reset();
        for (int r = 0; r < 4; r++)
            run_round(4'b1111, eq_attr, IDW'(r), 8'h40, $sformatf("tie_r%0d", r));

        req   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("noreq.busy0", busy, 0);
        tick();
        tick();
        chk("noreq.busy1", busy, 0);
        chk("noreq.gv", grant_valid, 0);
        run_round(4'b0100, '0, 2'd2, 8'h00, "zero_attr");

        req   = 4'b1111;
        attr  = eq_attr;
        start = 1'b1;
        tick();
        start = 1'b0;
        req   = '0;
        chk("drop.busy_on", busy, 1);
        repeat (N-1) tick();
        chk("drop.busy_mid", busy, 1);
        tick();
        chk("drop.busy_off", busy, 0);
        chk("drop.gv", grant_valid, 0);
        run_round(4'b1111, eq_attr, 2'd3, 8'h40, "drop_ptr");

        req   = 4'b0001;
        attr  = {24'h0, 8'h5A};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N) tick();
        chk("hold.gv0", grant_valid, 1);
        for (int c = 0; c < 10; c++) begin
            start = c[0];
            tick();
            chk($sformatf("hold.gv_c%0d", c), grant_valid, 1);
            chk($sformatf("hold.gid_c%0d", c), grant_id, 0);
            chk($sformatf("hold.gattr_c%0d", c), grant_attr, 8'h5A);
            chk($sformatf("hold.busy_c%0d", c), busy, 1);
        end
        start = 1'b0;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        chk("hold.busy_off", busy, 0);
        chk("hold.gv_off", grant_valid, 0);

        req   = 4'b1111;
        attr  = eq_attr;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        CLR = 1'b0;
        #1;
        chk_idle_outputs("clr_scan");
        tick();
        CLR = 1'b1;
        run_round(4'b1111, eq_attr, 2'd0, 8'h40, "after_clr_scan");

        req   = 4'b0100;
        attr  = {8'h00, 8'h77, 8'h00, 8'h00};
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (N) tick();
        chk("clr_grant.gv_pre", grant_valid, 1);
        chk("clr_grant.gattr_pre", grant_attr, 8'h77);
        #2;
        CLR = 1'b0;
        #1;
        chk_idle_outputs("clr_grant");
        tick();
        CLR = 1'b1;
        run_round(4'b1111, eq_attr, 2'd0, 8'h40, "after_clr_grant");

        do_reset();
`ifdef STARVE_GUARD_EN
        sid   = '{2'd0, 2'd0, 2'd0, 2'd1};
        sattr = '{8'hFF, 8'hFF, 8'hFF, 8'h01};
`else
        sid   = '{2'd0, 2'd0, 2'd0, 2'd0};
        sattr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
        for (int r = 0; r < 4; r++)
            run_round(4'b0011, starve_attr, sid[r], sattr[r], $sformatf("starve_r%0d", r));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
